// File: rtl/md_seq_if.sv
// Handshake/result bundle between the execute stage and the md_seq multiply/divide sequencer.
interface md_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         div0;

    modport master (
        output start, op, a, b,
        input  busy, stall, done, result, result_hi, div0
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall, done, result, result_hi, div0
    );
endinterface

// File: rtl/md_seq.sv
// Iterative unsigned multiply / divide sequencer: W-cycle shift-add MUL, restoring DIV/MOD.
// Define MD_SEQ_DIV_EN to build the divider and accept DIV/MOD; otherwise only MUL is valid.
module md_seq #(
    parameter int W = 8
) (
    input  logic      clk,
    input  logic      rst,
    md_seq_if.slave   bus
);
    localparam int CW = $clog2(W);
    localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef MD_SEQ_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_MOD = 4'b1010;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    result_q, result_d;
    logic [W-1:0]    result_hi_q, result_hi_d;
    logic            op_valid;
    logic            accept;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_acc;
    logic [2*W-1:0]  step_acc;
`ifdef MD_SEQ_DIV_EN
    logic            is_div_q, is_div_d;
    logic            is_mod_q, is_mod_d;
    logic            div0_q, div0_d;
    logic [W:0]      div_shift;
    logic [W:0]      div_diff;
    logic            div_ge;
    logic [2*W-1:0]  div_acc;

    assign op_valid = (bus.op == OP_MUL) || (bus.op == OP_DIV) || (bus.op == OP_MOD);
`else
    assign op_valid = (bus.op == OP_MUL);
`endif

    assign accept = bus.start && op_valid && (state_q == IDLE) && !rst;

    // acc = {high half, multiplier}; the multiplier drains out of the low end as the product shifts in.
    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign mul_acc = {mul_sum, acc_q[W-1:1]};

`ifdef MD_SEQ_DIV_EN
    // acc = {partial remainder, dividend/quotient}; quotient bits enter at the LSB.
    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_acc   = {(div_ge ? div_diff[W-1:0] : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
    assign step_acc  = is_div_q ? div_acc : mul_acc;
`else
    assign step_acc  = mul_acc;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opnd_d      = opnd_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
`ifdef MD_SEQ_DIV_EN
        is_div_d    = is_div_q;
        is_mod_d    = is_mod_q;
        div0_d      = div0_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = CW'(W - 1);
`ifdef MD_SEQ_DIV_EN
                    is_div_d = (bus.op != OP_MUL);
                    is_mod_d = (bus.op == OP_MOD);
                    div0_d   = 1'b0;
                    if (bus.op == OP_MUL) begin
                        opnd_d = bus.a;
                        acc_d  = {{W{1'b0}}, bus.b};
                    end else begin
                        opnd_d = bus.b;
                        acc_d  = {{W{1'b0}}, bus.a};
                    end
`else
                    opnd_d = bus.a;
                    acc_d  = {{W{1'b0}}, bus.b};
`endif
                end
            end
            RUN: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = DONE;
`ifdef MD_SEQ_DIV_EN
                    if (is_mod_q) begin
                        result_d    = step_acc[2*W-1:W];
                        result_hi_d = step_acc[W-1:0];
                    end else begin
                        result_d    = step_acc[W-1:0];
                        result_hi_d = step_acc[2*W-1:W];
                    end
                    div0_d = is_div_q && (opnd_q == '0);
`else
                    result_d    = step_acc[W-1:0];
                    result_hi_d = step_acc[2*W-1:W];
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
`ifdef MD_SEQ_DIV_EN
            is_div_q    <= 1'b0;
            is_mod_q    <= 1'b0;
            div0_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
`ifdef MD_SEQ_DIV_EN
            is_div_q    <= is_div_d;
            is_mod_q    <= is_mod_d;
            div0_q      <= div0_d;
`endif
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.stall     = accept || (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
`ifdef MD_SEQ_DIV_EN
    assign bus.div0      = div0_q;
`else
    assign bus.div0      = 1'b0;
`endif
endmodule
